// File: rtl/mod_mul_vec.sv
// mod_mul_vec: LANES-wide, three-stage (a*b [+ c]) mod Q pipeline using Barrett reduction.
// Define MOD_MUL_VEC_TAG_EN to add tag_i/tag_o, a side-band tag that travels with each beat.
module mod_mul_vec #(
    parameter int W     = 12,
    parameter int Q     = 3329,
    parameter int LANES = 4,
    parameter int TAG_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               valid_i,
    output logic               ready_o,
    input  logic               mode_i,
    input  logic [LANES*W-1:0] a_i,
    input  logic [LANES*W-1:0] b_i,
    input  logic [LANES*W-1:0] c_i,
`ifdef MOD_MUL_VEC_TAG_EN
    input  logic [TAG_W-1:0]   tag_i,
`endif
    output logic               valid_o,
    input  logic               ready_i,
    output logic [LANES*W-1:0] result_o
`ifdef MOD_MUL_VEC_TAG_EN
    ,
    output logic [TAG_W-1:0]   tag_o
`endif
);

    localparam int K  = 2 * W + 2;
    localparam int SW = 2 * W + 1;

    localparam logic [K:0]    TWO_K  = {1'b1, {K{1'b0}}};
    localparam logic [K:0]    Q_WIDE = (K + 1)'(Q);
    localparam logic [K-1:0]  M      = K'(TWO_K / Q_WIDE);
    localparam logic [SW-1:0] Q_SW   = SW'(Q);

    generate
        if (longint'(Q) >= (64'd1 << W) || Q < 2 || LANES < 1 || TAG_W < 1) begin : g_bad_params
            $error("mod_mul_vec: illegal parameter set");
        end
    endgenerate

    logic v1_reg, v2_reg, v3_reg;
    logic stall;
    logic advance;

    // A single stall freezes every stage at once, so bubbles keep their slots.
    assign stall   = v3_reg && !ready_i;
    assign advance = !stall;
    assign ready_o = advance;
    assign valid_o = v3_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v1_reg <= 1'b0;
            v2_reg <= 1'b0;
            v3_reg <= 1'b0;
        end else if (advance) begin
            v1_reg <= valid_i;
            v2_reg <= v1_reg;
            v3_reg <= v2_reg;
        end
    end

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            logic [W-1:0]    a_c, b_c, c_c;
            logic [2*W-1:0]  p_reg;
            logic [W-1:0]    c_reg;
            logic [SW-1:0]   s_reg, qhat_reg;
            logic [W-1:0]    r_reg;
            logic [SW-1:0]   s_c, qhat_c, r0_c, r1_c, r2_c;

            assign a_c = a_i[gi*W +: W];
            assign b_c = b_i[gi*W +: W];
            assign c_c = c_i[gi*W +: W];

            // qhat never exceeds s/Q, so r0 is non-negative and stays below 2Q;
            // the product qhat*Q may wrap in SW bits but the difference is exact.
            always_comb begin
                s_c    = SW'(p_reg) + SW'(c_reg);
                qhat_c = SW'(({{K{1'b0}}, s_c} * {{SW{1'b0}}, M}) >> K);
                r0_c   = s_reg - qhat_reg * Q_SW;
                r1_c   = (r0_c >= Q_SW) ? r0_c - Q_SW : r0_c;
                r2_c   = (r1_c >= Q_SW) ? r1_c - Q_SW : r1_c;
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    p_reg    <= '0;
                    c_reg    <= '0;
                    s_reg    <= '0;
                    qhat_reg <= '0;
                    r_reg    <= '0;
                end else if (advance) begin
                    p_reg    <= {{W{1'b0}}, a_c} * {{W{1'b0}}, b_c};
                    c_reg    <= mode_i ? c_c : '0;
                    s_reg    <= s_c;
                    qhat_reg <= qhat_c;
                    r_reg    <= W'(r2_c);
                end
            end

            assign result_o[gi*W +: W] = r_reg;
        end
    endgenerate

`ifdef MOD_MUL_VEC_TAG_EN
    logic [TAG_W-1:0] t1_reg, t2_reg, t3_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            t1_reg <= '0;
            t2_reg <= '0;
            t3_reg <= '0;
        end else if (advance) begin
            t1_reg <= tag_i;
            t2_reg <= t1_reg;
            t3_reg <= t2_reg;
        end
    end

    assign tag_o = t3_reg;
`endif

endmodule

// File: tb/tb_mod_mul_vec.sv
// Self-checking bench for mod_mul_vec: directed corners, random backpressure stream,
// mid-stream reset and two single-lane parameter sets, all against a longint model.
module tb_mod_mul_vec;

    localparam int W  = 12;
    localparam int Q  = 3329;
    localparam int L  = 4;
    localparam int NB = 256;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic           valid_i = 1'b0;
    logic           mode_i  = 1'b0;
    logic           ready_i = 1'b1;
    logic [L*W-1:0] a_i = '0, b_i = '0, c_i = '0;
    logic           ready_o, valid_o;
    logic [L*W-1:0] result_o;
`ifdef MOD_MUL_VEC_TAG_EN
    logic [7:0]     tag_i = '0;
    logic [7:0]     tag_o;
    logic [7:0]     t13_o, t23_o;
`endif

    mod_mul_vec #(.W(W), .Q(Q), .LANES(L), .TAG_W(8)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o), .mode_i(mode_i),
        .a_i(a_i), .b_i(b_i), .c_i(c_i),
`ifdef MOD_MUL_VEC_TAG_EN
        .tag_i(tag_i), .tag_o(tag_o),
`endif
        .valid_o(valid_o), .ready_i(ready_i), .result_o(result_o)
    );

    // Single-lane parameter sweep instances
    logic        s_valid = 1'b0, s_mode = 1'b0, s_ready = 1'b1;
    logic [12:0] a13 = '0, b13 = '0, c13 = '0, res13;
    logic [22:0] a23 = '0, b23 = '0, c23 = '0, res23;
    logic        v13, v23, rdy13, rdy23;

    mod_mul_vec #(.W(13), .Q(7681), .LANES(1), .TAG_W(8)) u13 (
        .clk(clk), .rst(rst), .valid_i(s_valid), .ready_o(rdy13), .mode_i(s_mode),
        .a_i(a13), .b_i(b13), .c_i(c13),
`ifdef MOD_MUL_VEC_TAG_EN
        .tag_i(8'h00), .tag_o(t13_o),
`endif
        .valid_o(v13), .ready_i(s_ready), .result_o(res13)
    );

    mod_mul_vec #(.W(23), .Q(8380417), .LANES(1), .TAG_W(8)) u23 (
        .clk(clk), .rst(rst), .valid_i(s_valid), .ready_o(rdy23), .mode_i(s_mode),
        .a_i(a23), .b_i(b23), .c_i(c23),
`ifdef MOD_MUL_VEC_TAG_EN
        .tag_i(8'h00), .tag_o(t23_o),
`endif
        .valid_o(v23), .ready_i(s_ready), .result_o(res23)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic longint ref_mm(input longint a, input longint b, input longint c,
                                      input bit mode, input longint q);
        return (a * b + (mode ? c : 64'd0)) % q;
    endfunction

    function automatic logic [L*W-1:0] ref_vec(input logic [L*W-1:0] a, input logic [L*W-1:0] b,
                                               input logic [L*W-1:0] c, input bit mode);
        logic [L*W-1:0] r;
        r = '0;
        for (int k = 0; k < L; k++)
            r[k*W +: W] = W'(ref_mm(longint'(a[k*W +: W]), longint'(b[k*W +: W]),
                                    longint'(c[k*W +: W]), mode, Q));
        return r;
    endfunction

    function automatic logic [L*W-1:0] rand_vec();
        return (L*W)'({$urandom, $urandom});
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    logic [L*W-1:0] exp_q[$];
    logic [7:0]     exp_tag_q[$];
    longint         e13_q[$], e23_q[$];

    initial begin
        logic [L*W-1:0] held_res;
        logic [7:0]     held_tag;
        logic           held;
        int             sent, got;
        held_tag = '0;

        // Reset state
        #1;
        check("rst_valid", 64'(valid_o), 64'd0);
        check("rst_result", 64'(result_o), 64'd0);
        check("rst_ready", 64'(ready_o), 64'd1);
`ifdef MOD_MUL_VEC_TAG_EN
        check("rst_tag", 64'(tag_o), 64'd0);
`endif
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Corner lanes, mode 0: valid_o rises on the third edge after the handshake cycle
        valid_i = 1'b1; mode_i = 1'b0; ready_i = 1'b1;
        a_i = {12'd1234, 12'd3328, 12'd1, 12'd0};
        b_i = {12'd0, 12'd3328, 12'd3328, 12'd0};
        c_i = rand_vec();
        #1 check("acc_ready", 64'(ready_o), 64'd1);
        @(posedge clk); #1 check("lat_e1", 64'(valid_o), 64'd0);
        @(negedge clk); valid_i = 1'b0;
        @(posedge clk); #1 check("lat_e2", 64'(valid_o), 64'd0);
        @(posedge clk); #1 check("lat_e3", 64'(valid_o), 64'd1);
        check("corner", 64'(result_o), 64'({12'd0, 12'd1, 12'd3328, 12'd0}));
        $display("[TB] corner beat result=%h", result_o);
        @(posedge clk); #1 check("lat_e4", 64'(valid_o), 64'd0);

        // Multiply-add wrap: two back-to-back beats
        @(negedge clk);
        valid_i = 1'b1; mode_i = 1'b1;
        a_i = {L{12'd3328}}; b_i = {L{12'd3328}}; c_i = {L{12'd3328}};
        @(negedge clk);
        a_i = {L{12'd2}}; b_i = {L{12'd1665}}; c_i = '0;
        @(negedge clk);
        valid_i = 1'b0;
        @(posedge clk); #1 check("madd_v1", 64'(valid_o), 64'd1);
        check("madd_wrap", 64'(result_o), 64'd0);
        $display("[TB] madd beat 1 result=%h", result_o);
        @(posedge clk); #1 check("madd_v2", 64'(valid_o), 64'd1);
        check("madd_one", 64'(result_o), 64'({L{12'd1}}));
        $display("[TB] madd beat 2 result=%h", result_o);
        @(posedge clk); #1 check("madd_v3", 64'(valid_o), 64'd0);

        // Random stream under random backpressure; tags count 0..255 in acceptance order
        @(negedge clk);
        sent = 0; got = 0; held = 1'b0; held_res = '0;
        for (int cyc = 0; cyc < 4000 && got < NB; cyc++) begin
            if (sent < NB && $urandom_range(0, 3) != 0) begin
                valid_i = 1'b1;
                mode_i  = 1'($urandom_range(0, 1));
                a_i = rand_vec(); b_i = rand_vec(); c_i = rand_vec();
`ifdef MOD_MUL_VEC_TAG_EN
                tag_i = 8'(sent);
`endif
            end else begin
                valid_i = 1'b0;
            end
            ready_i = ($urandom_range(0, 2) != 0);
            #1;
            if (held) begin
                check("hold_result", 64'(result_o), 64'(held_res));
`ifdef MOD_MUL_VEC_TAG_EN
                check("hold_tag", 64'(tag_o), 64'(held_tag));
`endif
            end
            if (valid_o && !ready_i) begin
                check("stall_ready", 64'(ready_o), 64'd0);
                held = 1'b1;
                held_res = result_o;
`ifdef MOD_MUL_VEC_TAG_EN
                held_tag = tag_o;
`endif
            end else begin
                held = 1'b0;
            end
            if (valid_i && ready_o) begin
                exp_q.push_back(ref_vec(a_i, b_i, c_i, mode_i));
                exp_tag_q.push_back(8'(sent));
                sent++;
            end
            if (valid_o && ready_i) begin
                if (exp_q.size() == 0) begin
                    check("sb_empty", 64'd1, 64'd0);
                end else begin
                    check("stream", 64'(result_o), 64'(exp_q.pop_front()));
`ifdef MOD_MUL_VEC_TAG_EN
                    check("stream_tag", 64'(tag_o), 64'(exp_tag_q.pop_front()));
`else
                    void'(exp_tag_q.pop_front());
`endif
                end
                $display("[TB] stream beat %0d result=%h", got, result_o);
                got++;
            end
            @(negedge clk);
        end
        check("stream_done", 64'(got), 64'(NB));
        valid_i = 1'b0; ready_i = 1'b1;

        // Reset mid-stream with three beats in flight
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            valid_i = 1'b1; mode_i = 1'b0;
            a_i = rand_vec(); b_i = rand_vec();
            @(negedge clk);
        end
        valid_i = 1'b0;
        #1 check("mid_pre_valid", 64'(valid_o), 64'd1);
        #1 rst = 1'b0;
        #1 check("mid_rst_valid", 64'(valid_o), 64'd0);
        check("mid_rst_ready", 64'(ready_o), 64'd1);
        $display("[TB] reset asserted mid-stream");
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1 check("no_stale", 64'(valid_o), 64'd0);
        end

        // Parameter sweep: 500 beats per mode, one per cycle, ready held high
        @(negedge clk);
        for (int i = 0; i < 1004; i++) begin
            if (i < 1000) begin
                s_valid = 1'b1;
                s_mode  = (i >= 500);
                if (i % 37 == 0) begin
                    a13 = '1; b13 = '1; c13 = '1;
                    a23 = '1; b23 = '1; c23 = '1;
                end else begin
                    a13 = 13'($urandom); b13 = 13'($urandom); c13 = 13'($urandom);
                    a23 = 23'($urandom); b23 = 23'($urandom); c23 = 23'($urandom);
                end
            end else begin
                s_valid = 1'b0;
            end
            #1;
            if (s_valid && rdy13) e13_q.push_back(ref_mm(a13, b13, c13, s_mode, 7681));
            if (s_valid && rdy23) e23_q.push_back(ref_mm(a23, b23, c23, s_mode, 8380417));
            if (v13) begin
                if (e13_q.size() == 0) check("sb13_empty", 64'd1, 64'd0);
                else check("sweep_q7681", 64'(res13), 64'(e13_q.pop_front()));
            end
            if (v23) begin
                if (e23_q.size() == 0) check("sb23_empty", 64'd1, 64'd0);
                else check("sweep_q8380417", 64'(res23), 64'(e23_q.pop_front()));
            end
            if (v13 || v23) $display("[TB] sweep beat r13=%0d r23=%0d", res13, res23);
            @(negedge clk);
        end
        check("sweep13_drain", 64'(e13_q.size()), 64'd0);
        check("sweep23_drain", 64'(e23_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
